serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_add_ctrl_halfadder.sv | 12 +
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and default operand width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_halfadder.sv
// Single-bit half adder; two of these plus an OR form one full-adder bit slice.
module Halfadder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshakes: one sum bit per cycle, LSB first,
// result presented after WIDTH+1 edges and held until the consumer accepts it.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic w_p;
    logic w_g0;
    logic w_s;
    logic w_g1;
    logic w_c;

    Halfadder u_ha0 (
        .i_a     (r_a[0]),
        .i_b     (r_b[0]),
        .o_sum   (w_p),
        .o_carry (w_g0)
    );

    Halfadder u_ha1 (
        .i_a     (w_p),
        .i_b     (r_carry),
        .o_sum   (w_s),
        .o_carry (w_g1)
    );

    assign w_c = w_g0 | w_g1;

    // Operand shift registers carry no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && in_valid) begin
            r_a <= a;
            r_b <= b;
        end else if (r_state == ST_RUN) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state    <= ST_RUN;
                        r_carry    <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // New bit enters at the MSB so bit i settles at sum[i] after WIDTH shifts.
                    r_sum   <= WIDTH'({w_s, r_sum} >> 1);
                    r_carry <= w_c;
                    if (r_cnt == LAST_BIT) begin
                        r_state     <= ST_DONE;
                        r_cout      <= w_c;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule
